// File: rtl/byte_word_packer_if.sv
// rtl/byte_word_packer_if.sv - byte-in / word-out handshake bundle for byte_word_packer
//
// Purpose: groups the byte input handshake, the byte-enabled word output and
//          the hand-off counter into one bundle.
// Signals:
//   in_valid, in_byte[7:0], in_last  byte stream from the upstream source
//   in_ready                         packer accepts a byte this cycle
//   out_ready                        downstream register takes the pending word
//   out_valid, D[15:0], byteena[1:0] pending byte-enabled write
//   word_count[15:0]                 words handed off (wraps at 16'hFFFF)
// Modports: master = source/sink side, slave = the packer.

interface byte_word_packer_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] D;
  logic [1:0]  byteena;
  logic [15:0] word_count;

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, D, byteena, word_count
  );

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, D, byteena, word_count
  );
endinterface

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a byte stream into byte-enabled 16-bit writes
//
// Purpose: collects one or two bytes into a 16-bit word (low byte first) and
//          presents it with a lane mask to a byte-enabled register.
//          States: EMPTY (nothing held), HALF (low byte held), FULL (word pending).
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous, active-high
//   bus    - byte_word_packer_if.slave (byte input, word output, word_count)
// Parameter:
//   TIMEOUT_CYCLES - idle HALF cycles before a lone low byte is flushed
// Configuration macro:
//   BWP_TIMEOUT_EN - when defined, a lone low byte is flushed as a 2'b01 word
//                    after TIMEOUT_CYCLES idle cycles; otherwise HALF waits
//                    indefinitely and TIMEOUT_CYCLES is ignored.

module byte_word_packer #(
  parameter int TIMEOUT_CYCLES = 8
) (
  input  logic                clk,
  input  logic                reset,
  byte_word_packer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_d;
  logic [1:0]  r_byteena;
  logic        r_out_valid;
  logic        r_in_ready;
  logic [15:0] r_word_count;
  logic        w_accept;

  assign w_accept = bus.in_valid && r_in_ready;

`ifdef BWP_TIMEOUT_EN
  // Counter runs 0 .. TIMEOUT_CYCLES-1; the cycle it sits at the last value
  // is the TIMEOUT_CYCLES-th idle cycle, so that edge flushes the word.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_timeout;
  logic          w_expired;

  assign w_expired = (r_timeout == TO_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_EMPTY;
      r_d          <= 16'h0000;
      r_byteena    <= 2'b00;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_word_count <= 16'h0000;
`ifdef BWP_TIMEOUT_EN
      r_timeout    <= '0;
`endif
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            // Loading the high lane with zero keeps single-byte words clean.
            r_d <= {8'h00, bus.in_byte};
            if (bus.in_last) begin
              r_state     <= S_FULL;
              r_byteena   <= 2'b01;
              r_out_valid <= 1'b1;
              r_in_ready  <= 1'b0;
            end else begin
              r_state     <= S_HALF;
            end
          end
        end

        S_HALF: begin
          // A byte arriving on the expiry cycle wins over the flush.
          if (w_accept) begin
            r_d[15:8]   <= bus.in_byte;
            r_state     <= S_FULL;
            r_byteena   <= 2'b11;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
`ifdef BWP_TIMEOUT_EN
            r_timeout   <= '0;
          end else if (w_expired) begin
            r_state     <= S_FULL;
            r_byteena   <= 2'b01;
            r_out_valid <= 1'b1;
            r_in_ready  <= 1'b0;
            r_timeout   <= '0;
          end else begin
            r_timeout   <= r_timeout + 1'b1;
`endif
          end
        end

        S_FULL: begin
          if (bus.out_ready) begin
            r_state      <= S_EMPTY;
            r_byteena    <= 2'b00;
            r_out_valid  <= 1'b0;
            r_in_ready   <= 1'b1;
            r_word_count <= r_word_count + 16'd1;
          end
        end

        default: begin
          r_state     <= S_EMPTY;
          r_byteena   <= 2'b00;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.D          = r_d;
  assign bus.byteena    = r_byteena;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - self-checking bench for byte_word_packer

module tb_byte_word_packer;

  localparam int TO = 8;

  logic clk;
  logic reset;

  byte_word_packer_if bus ();

  byte_word_packer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level reference: bytes gathered in a queue, one pending word.
  logic [7:0]  m_buf [$];
  logic        m_pend;
  logic [15:0] m_word;
  logic [1:0]  m_mask;
  logic [15:0] m_count;
  int          m_idle;
  logic        m_fresh;

  task automatic model_step();
    if (reset) begin
      m_buf.delete();
      m_pend  = 1'b0;
      m_word  = 16'h0;
      m_mask  = 2'b00;
      m_count = 16'h0;
      m_idle  = 0;
      m_fresh = 1'b1;
      return;
    end
    if (m_pend) begin
      if (bus.out_ready) begin
        m_pend  = 1'b0;
        m_count = m_count + 16'd1;
      end
    end else if (bus.in_valid) begin
      m_fresh = 1'b0;
      m_idle  = 0;
      m_buf.push_back(bus.in_byte);
      if (m_buf.size() == 2) begin
        m_word = {m_buf[1], m_buf[0]};
        m_mask = 2'b11;
        m_pend = 1'b1;
        m_buf.delete();
      end else if (bus.in_last) begin
        m_word = {8'h00, m_buf[0]};
        m_mask = 2'b01;
        m_pend = 1'b1;
        m_buf.delete();
      end
    end
`ifdef BWP_TIMEOUT_EN
    else if (m_buf.size() == 1) begin
      m_idle++;
      if (m_idle == TO) begin
        m_word = {8'h00, m_buf[0]};
        m_mask = 2'b01;
        m_pend = 1'b1;
        m_idle = 0;
        m_buf.delete();
      end
    end
`endif
  endtask

  task automatic compare();
    logic [1:0] exp_be;
    bit ok;
    exp_be = m_pend ? m_mask : 2'b00;
    ok = (bus.in_ready === !m_pend) && (bus.out_valid === m_pend) &&
         (bus.byteena === exp_be) && (bus.word_count === m_count) &&
         (!m_pend || bus.D === m_word) && (!m_fresh || bus.D === 16'h0000);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got rdy=%b vld=%b be=%b D=%h wc=%h required rdy=%b vld=%b be=%b D=%h wc=%h",
               $time, bus.in_ready, bus.out_valid, bus.byteena, bus.D, bus.word_count,
               !m_pend, m_pend, exp_be, m_pend ? m_word : 16'h0, m_count);
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic l);
    bus.in_valid = v;
    bus.in_byte  = b;
    bus.in_last  = l;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_byte   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    m_pend = 1'b0; m_word = 0; m_mask = 0; m_count = 0; m_idle = 0; m_fresh = 1'b1;

    // Reset state and first cycle after release
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_byteena", {30'b0, bus.byteena}, 32'd0);
    check("rst_D", {16'b0, bus.D}, 32'h0);
    check("rst_word_count", {16'b0, bus.word_count}, 32'd0);

    // Reset while holding a low byte discards it
    drive(1, 8'h77, 0);
    tick();
    drive(0, 8'h00, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("half_rst_byteena", {30'b0, bus.byteena}, 32'd0);
    check("half_rst_D", {16'b0, bus.D}, 32'h0);
    check("half_rst_wc", {16'b0, bus.word_count}, 32'd0);
    tick();

    // Two-byte word, immediate hand-off
    bus.out_ready = 1'b1;
    drive(1, 8'hAA, 0);
    tick();
    drive(1, 8'h55, 0);
    tick();
    drive(0, 8'h00, 0);
    check("w2_valid", {31'b0, bus.out_valid}, 32'd1);
    check("w2_D", {16'b0, bus.D}, 32'h55AA);
    check("w2_be", {30'b0, bus.byteena}, 32'd3);
    tick();
    check("w2_done", {31'b0, bus.out_valid}, 32'd0);
    check("w2_wc", {16'b0, bus.word_count}, 32'd1);

    // Single byte closed by in_last
    drive(1, 8'h3C, 1);
    tick();
    drive(0, 8'h00, 0);
    check("w1_D", {16'b0, bus.D}, 32'h003C);
    check("w1_be", {30'b0, bus.byteena}, 32'd1);
    tick();
    check("w1_wc", {16'b0, bus.word_count}, 32'd2);

    // Sustained stream: one word per 3 cycles
    for (int i = 0; i < 9; i++) begin
      drive(1, 8'(8'h10 + i), 0);
      tick();
    end
    drive(0, 8'h00, 0);
    check("stream_wc", {16'b0, bus.word_count}, 32'd5);

    // Back-pressure holds the word and blocks input
    bus.out_ready = 1'b0;
    drive(1, 8'h11, 0);
    tick();
    drive(1, 8'hCC, 0);
    tick();
    drive(1, 8'hEE, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_D", {16'b0, bus.D}, 32'hCC11);
      check("stall_be", {30'b0, bus.byteena}, 32'd3);
      check("stall_rdy", {31'b0, bus.in_ready}, 32'd0);
    end
    drive(0, 8'h00, 0);
    bus.out_ready = 1'b1;
    tick();
    check("stall_release_vld", {31'b0, bus.out_valid}, 32'd0);
    check("stall_release_wc", {16'b0, bus.word_count}, 32'd6);
    tick();
    check("stall_after_vld", {31'b0, bus.out_valid}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 249) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < (((i / 400) % 2 == 1) ? 1 : 7));
      bus.in_byte   = 8'($urandom);
      bus.in_last   = ($urandom_range(0, 4) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0;
    drive(0, 8'h00, 0);

`ifdef BWP_TIMEOUT_EN
    // Flush of a lone byte after TO idle cycles, and a byte winning at expiry
    bus.out_ready = 1'b0;
    do_reset();
    drive(1, 8'h9E, 0);
    tick();
    drive(0, 8'h00, 0);
    for (int i = 0; i < TO - 1; i++) tick();
    check("to_not_yet", {31'b0, bus.out_valid}, 32'd0);
    tick();
    check("to_valid", {31'b0, bus.out_valid}, 32'd1);
    check("to_D", {16'b0, bus.D}, 32'h009E);
    check("to_be", {30'b0, bus.byteena}, 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    drive(1, 8'h9E, 0);
    tick();
    drive(0, 8'h00, 0);
    for (int i = 0; i < TO - 1; i++) tick();
    drive(1, 8'h5A, 0);
    tick();
    drive(0, 8'h00, 0);
    check("to_race_be", {30'b0, bus.byteena}, 32'd3);
    check("to_race_D", {16'b0, bus.D}, 32'h5A9E);
    bus.out_ready = 1'b1;
    tick();
`endif

    // word_count wrap: jump the counter near the top, then hand off two words
    bus.out_ready = 1'b1;
    do_reset();
    force dut.r_word_count = 16'hFFFE;
    m_count = 16'hFFFE;
    tick();
    release dut.r_word_count;
    tick();
    drive(1, 8'h01, 1);
    tick();
    drive(0, 8'h00, 0);
    tick();
    check("wrap_ffff", {16'b0, bus.word_count}, 32'h0000FFFF);
    drive(1, 8'h02, 1);
    tick();
    drive(0, 8'h00, 0);
    tick();
    check("wrap_zero", {16'b0, bus.word_count}, 32'h00000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
